// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multi-cycle MIPS control FSM with a memory request/ready handshake,
// a wait-state timeout and precise exceptions.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   opcode, funct            instruction fields from IR
//   zero, overflow           ALU flags
//   bltz_cond                rs[31], taken condition for bltzal
//   mem_rdy                  memory completes the current request this cycle
//   irq                      level interrupt request, sampled in DECODE only
//   pc_wr, ir_wr, gpr_wr,
//   dm_wr, epc_wr            datapath write enables
//   mem_req                  memory request, held until mem_rdy (or timeout)
//   npc_sel, alu_ctr, reg_dst,
//   reg_from_sel, b_sel,
//   byte_sel, ext_op         datapath mux selects
//   exc                      exception state active
//   cause                    last exception cause, held until the next one
//   fsm_state                current state, for observation
//
// Handshake: a request is presented by holding mem_req high; the transfer
// completes in the cycle where mem_req and mem_rdy are both high. mem_rdy in
// any cycle without mem_req is ignored.
module mc_ctrl_hs #(
    parameter int unsigned TO_CYCLES = 15,
    parameter int unsigned CNT_W     = 4,
    parameter logic [2:0]  VEC_SEL   = 3'b100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       bltz_cond,
    input  logic       mem_rdy,
    input  logic       irq,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       gpr_wr,
    output logic       dm_wr,
    output logic       mem_req,
    output logic [2:0] npc_sel,
    output logic [2:0] alu_ctr,
    output logic [1:0] reg_dst,
    output logic [1:0] reg_from_sel,
    output logic       b_sel,
    output logic       byte_sel,
    output logic [1:0] ext_op,
    output logic       epc_wr,
    output logic       exc,
    output logic [1:0] cause,
    output logic [3:0] fsm_state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXE    = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        EXC    = 4'd10
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       cause_q, cause_n;

    // Instruction decode (IR is stable from DECODE onwards)
    logic is_r, op_addu, op_subu, op_slt, op_jr;
    logic op_addi, op_addiu, op_ori, op_lui, op_lw, op_sw, op_lb, op_sb;
    logic op_beq, op_j, op_jal, op_bltzal;
    logic is_load, is_store, is_alu, is_branch, is_jump, illegal;

    assign is_r      = (opcode == 6'b000000);
    assign op_addu   = is_r && (funct == 6'b100001);
    assign op_subu   = is_r && (funct == 6'b100011);
    assign op_slt    = is_r && (funct == 6'b101010);
    assign op_jr     = is_r && (funct == 6'b001000);
    assign op_addi   = (opcode == 6'b001000);
    assign op_addiu  = (opcode == 6'b001001);
    assign op_ori    = (opcode == 6'b001101);
    assign op_lui    = (opcode == 6'b001111);
    assign op_lw     = (opcode == 6'b100011);
    assign op_sw     = (opcode == 6'b101011);
    assign op_lb     = (opcode == 6'b100000);
    assign op_sb     = (opcode == 6'b101000);
    assign op_beq    = (opcode == 6'b000100);
    assign op_j      = (opcode == 6'b000010);
    assign op_jal    = (opcode == 6'b000011);
    assign op_bltzal = (opcode == 6'b000001);

    assign is_load   = op_lw || op_lb;
    assign is_store  = op_sw || op_sb;
    assign is_alu    = op_addu || op_subu || op_slt || op_addi || op_addiu || op_ori || op_lui;
    assign is_branch = op_beq || op_bltzal;
    assign is_jump   = op_j || op_jal || op_jr;
    assign illegal   = !(is_load || is_store || is_alu || is_branch || is_jump);

    // Timeout fires only when the last allowed wait cycle also sees no ready
    logic timeout;
    assign timeout = (cnt_q == CNT_W'(TO_CYCLES)) && !mem_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_n;
            cause_q <= cause_n;
            // Only the wait states loop on themselves, so any state change is
            // an entry into a fresh request (or a non-waiting state).
            if (state_n != state_q) cnt_q <= '0;
            else if (!mem_rdy)      cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Ungated combinational outputs; reset masking is applied below
    logic       pc_wr_c, ir_wr_c, gpr_wr_c, dm_wr_c, mem_req_c, epc_wr_c, exc_c;
    logic       b_sel_c, byte_sel_c;
    logic [2:0] npc_sel_c, alu_ctr_c;
    logic [1:0] reg_dst_c, reg_from_sel_c, ext_op_c;

    always_comb begin
        state_n        = state_q;
        cause_n        = cause_q;
        pc_wr_c        = 1'b0;
        ir_wr_c        = 1'b0;
        gpr_wr_c       = 1'b0;
        dm_wr_c        = 1'b0;
        mem_req_c      = 1'b0;
        epc_wr_c       = 1'b0;
        exc_c          = 1'b0;
        b_sel_c        = 1'b0;
        byte_sel_c     = 1'b0;
        npc_sel_c      = 3'b000;
        alu_ctr_c      = 3'b000;
        reg_dst_c      = 2'b00;
        reg_from_sel_c = 2'b00;
        ext_op_c       = 2'b00;
        case (state_q)
            FETCH: begin
                mem_req_c = 1'b1;
                if (mem_rdy) begin
                    ir_wr_c = 1'b1;
                    pc_wr_c = 1'b1;
                    state_n = DECODE;
                end else if (timeout) begin
                    cause_n = 2'b11;
                    state_n = EXC;
                end
            end
            DECODE: begin
                if (irq) begin
                    cause_n = 2'b00;
                    state_n = EXC;
                end else if (illegal) begin
                    cause_n = 2'b01;
                    state_n = EXC;
                end else if (is_load || is_store) state_n = MEMADR;
                else if (is_alu)                  state_n = EXE;
                else if (is_branch)               state_n = BRANCH;
                else                              state_n = JUMP;
            end
            MEMADR: begin
                alu_ctr_c = 3'b000;
                b_sel_c   = 1'b1;
                ext_op_c  = 2'b01;
                state_n   = is_load ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req_c = 1'b1;
                if (mem_rdy) state_n = MEMWB;
                else if (timeout) begin
                    cause_n = 2'b11;
                    state_n = EXC;
                end
            end
            MEMWB: begin
                gpr_wr_c       = 1'b1;
                reg_from_sel_c = 2'b01;
                byte_sel_c     = op_lb;
                state_n        = FETCH;
            end
            MEMWR: begin
                mem_req_c  = 1'b1;
                dm_wr_c    = 1'b1;
                byte_sel_c = op_sb;
                if (mem_rdy) state_n = FETCH;
                else if (timeout) begin
                    cause_n = 2'b11;
                    state_n = EXC;
                end
            end
            EXE: begin
                if (op_subu)                  alu_ctr_c = 3'b001;
                else if (op_ori)              alu_ctr_c = 3'b010;
                else if (op_addi)             alu_ctr_c = 3'b011;
                else if (op_slt)              alu_ctr_c = 3'b100;
                else if (op_lui)              alu_ctr_c = 3'b101;
                b_sel_c = op_addi || op_addiu || op_ori || op_lui;
                if (op_addi || op_addiu)      ext_op_c = 2'b01;
                else if (op_lui)              ext_op_c = 2'b10;
                state_n = ALUWB;
            end
            ALUWB: begin
                // A trapping addi must leave rt untouched
                if (op_addi && overflow) begin
                    cause_n = 2'b10;
                    state_n = EXC;
                end else begin
                    gpr_wr_c  = 1'b1;
                    reg_dst_c = is_r ? 2'b01 : 2'b00;
                    state_n   = FETCH;
                end
            end
            BRANCH: begin
                npc_sel_c = 3'b011;
                pc_wr_c   = (op_beq && zero) || (op_bltzal && bltz_cond);
                if (op_bltzal) begin
                    gpr_wr_c       = 1'b1;
                    reg_dst_c      = 2'b10;
                    reg_from_sel_c = 2'b10;
                end
                state_n = FETCH;
            end
            JUMP: begin
                pc_wr_c   = 1'b1;
                npc_sel_c = op_jr ? 3'b010 : 3'b001;
                if (op_jal) begin
                    gpr_wr_c       = 1'b1;
                    reg_dst_c      = 2'b10;
                    reg_from_sel_c = 2'b10;
                end
                state_n = FETCH;
            end
            EXC: begin
                exc_c     = 1'b1;
                epc_wr_c  = 1'b1;
                pc_wr_c   = 1'b1;
                npc_sel_c = VEC_SEL;
                state_n   = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    // Reset masks every output combinationally so a pending request drops at once
    assign pc_wr        = pc_wr_c    && !rst;
    assign ir_wr        = ir_wr_c    && !rst;
    assign gpr_wr       = gpr_wr_c   && !rst;
    assign dm_wr        = dm_wr_c    && !rst;
    assign mem_req      = mem_req_c  && !rst;
    assign epc_wr       = epc_wr_c   && !rst;
    assign exc          = exc_c      && !rst;
    assign b_sel        = b_sel_c    && !rst;
    assign byte_sel     = byte_sel_c && !rst;
    assign npc_sel      = rst ? 3'b000 : npc_sel_c;
    assign alu_ctr      = rst ? 3'b000 : alu_ctr_c;
    assign reg_dst      = rst ? 2'b00  : reg_dst_c;
    assign reg_from_sel = rst ? 2'b00  : reg_from_sel_c;
    assign ext_op       = rst ? 2'b00  : ext_op_c;
    assign cause        = cause_q;
    assign fsm_state    = state_q;

endmodule

// File: doc/mc_ctrl_hs.md
# mc_ctrl_hs

Multi-cycle MIPS control FSM for the next-generation core: same instruction subset and datapath select encodings as the current multi-cycle controller, plus a request/ready handshake to variable-latency instruction/data memory. Adds a parametrised wait-state timeout and precise exceptions (illegal opcode, addi overflow, memory timeout, external interrupt). Sits between the IR/flag outputs of the datapath and every datapath write-enable and mux select.

## Interface
- TO_CYCLES, 15: max cycles a memory request may wait for mem_rdy before a timeout exception (1..2^CNT_W-1)
- CNT_W, 4: width of the wait counter
- VEC_SEL, 3'b100: npc_sel code selecting the exception vector

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed-overflow flag
- bltz_cond  in  1  rs[31], condition for bltzal
- mem_rdy  in  1  memory completes current request this cycle
- irq  in  1  level interrupt request
- pc_wr, ir_wr, gpr_wr, dm_wr  out  1 each  write enables
- mem_req  out  1  memory request, held until mem_rdy
- npc_sel  out  3  000 pc+4, 001 j/jal, 010 jr, 011 branch, VEC_SEL vector
- alu_ctr  out  3  000 add, 001 sub, 010 or, 011 addi, 100 slt, 101 lui
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- reg_from_sel  out  2  00 ALU, 01 memory, 10 pc+4
- b_sel, byte_sel  out  1 each  imm16 operand; byte access
- ext_op  out  2  00 zero, 01 sign, 10 lui
- epc_wr  out  1  datapath captures faulting-instruction address into EPC
- exc  out  1  exception state active
- cause  out  2  00 irq, 01 illegal, 10 overflow, 11 timeout; held until next exception

## Operation
- Supported: addu subu slt jr addi addiu ori lui lw sw lb sb beq j jal bltzal (opcode 000001). Anything else is illegal.
- States (4-bit): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXE, ALUWB, BRANCH, JUMP, EXC.
- FETCH: mem_req=1; on mem_rdy: ir_wr=1, pc_wr=1, npc_sel=000, go DECODE.
- DECODE: if irq -> EXC cause 00 (instruction not executed); else illegal -> EXC cause 01; else load/store -> MEMADR, ALU class -> EXE, beq/bltzal -> BRANCH, j/jal/jr -> JUMP.
- MEMADR: alu_ctr=000, b_sel=1, ext_op=01; loads -> MEMRD, stores -> MEMWR.
- MEMRD: mem_req=1; on mem_rdy -> MEMWB. MEMWB: gpr_wr=1, reg_from_sel=01, reg_dst=00, byte_sel=lb -> FETCH.
- MEMWR: mem_req=1, dm_wr=1, byte_sel=sb; on mem_rdy -> FETCH.
- EXE: alu_ctr per op, b_sel for immediates, ext_op per op -> ALUWB.
- ALUWB: addi with overflow -> gpr_wr=0, go EXC cause 10; else gpr_wr=1, reg_dst=01 for R-type else 00 -> FETCH.
- BRANCH: npc_sel=011; pc_wr=(beq&zero)|(bltzal&bltz_cond); bltzal: gpr_wr=1, reg_dst=10, reg_from_sel=10 regardless of condition -> FETCH.
- JUMP: pc_wr=1, npc_sel 001 (j/jal) or 010 (jr); jal: gpr_wr=1, reg_dst=10, reg_from_sel=10 -> FETCH.
- EXC: one cycle; exc=1, epc_wr=1, pc_wr=1, npc_sel=VEC_SEL -> FETCH. cause register loads on EXC entry.
- Select outputs not listed for a state are 0.

## Timing
- rst asserted: state=FETCH, wait counter=0, cause=00; all outputs 0 (mem_req gated by rst) while rst high; first request the cycle after deassertion.
- Wait counter clears on entry to FETCH/MEMRD/MEMWR, increments each cycle mem_rdy=0. When count==TO_CYCLES and mem_rdy=0 -> EXC cause 11; mem_req drops in EXC. mem_rdy=1 in the same cycle as count==TO_CYCLES completes normally.
- mem_rdy outside FETCH/MEMRD/MEMWR is ignored.
- Zero-wait memory: R-type 4 cycles, lw 5, sw 4, beq 3, j 3; each extra wait cycle adds 1.
- irq sampled only in DECODE; irq in other states is held off until next DECODE.
- Reset mid-wait aborts the request immediately (mem_req=0 asynchronously).

## Test plan
- addu, mem_rdy tied 1: FETCH,DECODE,EXE,ALUWB in 4 cycles; gpr_wr=1 and reg_dst=01 only in ALUWB.
- lw with mem_rdy delayed 3 cycles in MEMRD: mem_req high 4 cycles, MEMWB gpr_wr=1, reg_from_sel=01; total 8 cycles.
- TO_CYCLES=15, mem_rdy never high in FETCH: EXC after 16 wait cycles, cause=11, npc_sel=100, pc_wr=epc_wr=1; mem_rdy on 16th cycle instead completes fetch.
- addi with overflow=1: ALUWB gpr_wr=0, then EXC cause=10; addi without overflow writes rt.
- opcode 6'b111111: DECODE -> EXC cause 01; irq=1 with valid lw in DECODE -> EXC cause 00, no dm/gpr writes.
- bltzal bltz_cond=0: pc_wr=0, gpr_wr=1 reg_dst=10; rst asserted in MEMWR wait: outputs 0 same cycle, FETCH after release.
